// File: rtl/ciclo_monitor_fsm.sv
// Watches the free-running cycle register: flags threshold matches and wraps,
// counts wraps and raises a sticky alarm after WRAP_LIMIT of them until acked.
//
// state | meaning
// IDLE  | monitoring off, prev held, ack clears wrap_count
// PRIME | first sample captured into prev, nothing evaluated yet
// TRACK | every sample compared against prev and threshold
// ALARM | wrap limit reached, frozen until ack
module ciclo_monitor_fsm #(
  parameter int WIDTH      = 8,
  parameter int WRAP_LIMIT = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] threshold,
  input  logic             ack,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic             alarm,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    TRACK = 2'b10,
    ALARM = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WRAP_LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_d;
  logic             is_wrap, is_match;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      match_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    match_d  = 1'b0;
    wrap_d   = 1'b0;
    cnt_d    = cnt_q;
    alarm_d  = alarm_q;
    // A held value equal to threshold must not re-fire, hence the prev check.
    is_wrap  = (count_in < prev_q);
    is_match = (count_in == threshold) && (prev_q != threshold);
    cnt_inc  = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (ack)    cnt_d   = '0;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (ack) cnt_d = '0;
        prev_d  = count_in;
        state_d = enable ? TRACK : IDLE;
      end
      TRACK: begin
        if (!enable) begin
          state_d = IDLE;
          if (ack) cnt_d = '0;
        end else begin
          prev_d  = count_in;
          wrap_d  = is_wrap;
          match_d = is_match;
          // ack wins over a same-cycle increment, so the alarm cannot rise then.
          if (ack) begin
            cnt_d = '0;
          end else if (is_wrap) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LIMIT) begin
              alarm_d = 1'b1;
              state_d = ALARM;
            end
          end
        end
      end
      ALARM: begin
        if (ack) begin
          alarm_d = 1'b0;
          cnt_d   = '0;
          state_d = enable ? PRIME : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign match_pulse = match_q;
  assign wrap_pulse  = wrap_q;
  assign wrap_count  = cnt_q;
  assign alarm       = alarm_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ciclo_monitor_fsm.sv
// Directed bench for ciclo_monitor_fsm: free-run wraps to alarm, ack restart,
// held values, downward steps, ack/wrap collision and async reset.
module tb_ciclo_monitor_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] count_in = '0;
  logic [7:0] threshold = 8'd10;
  logic       ack = 1'b0;
  logic       match_pulse, wrap_pulse, alarm;
  logic [3:0] wrap_count;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  ciclo_monitor_fsm #(.WIDTH(8), .WRAP_LIMIT(4), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .count_in    (count_in),
    .threshold   (threshold),
    .ack         (ack),
    .match_pulse (match_pulse),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .alarm       (alarm),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int m, input int w,
                         input int cnt, input int al);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".match"}, 32'(match_pulse), 32'(m));
    chk({tag, ".wrap"}, 32'(wrap_pulse), 32'(w));
    chk({tag, ".count"}, 32'(wrap_count), 32'(cnt));
    chk({tag, ".alarm"}, 32'(alarm), 32'(al));
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;

    // Start-up: IDLE -> PRIME -> TRACK, first lap with one match at 10.
    enable = 1'b1; count_in = 8'd0;
    tick(); chk_all("prime", 1, 0, 0, 0, 0);
    count_in = 8'd1;
    tick(); chk_all("track_entry", 2, 0, 0, 0, 0);
    for (int c = 2; c < 256; c++) begin
      count_in = 8'(c);
      tick(); chk_all("lap0", 2, (c == 10) ? 1 : 0, 0, 0, 0);
    end

    // Three full laps: one wrap per 255->0.
    for (int lap = 1; lap <= 3; lap++) begin
      for (int c = 0; c < 256; c++) begin
        count_in = 8'(c);
        tick(); chk_all("lap", 2, (c == 10) ? 1 : 0, (c == 0) ? 1 : 0, lap, 0);
      end
    end

    // Fourth wrap raises the alarm on the same edge.
    count_in = 8'd0;
    tick(); chk_all("alarm_rise", 3, 0, 1, 4, 1);
    for (int c = 1; c <= 20; c++) begin
      count_in = 8'(c);
      enable = (c > 12) ? 1'b0 : 1'b1;
      tick(); chk_all("alarm_frozen", 3, 0, 0, 4, 1);
    end

    // ack with enable=1 restarts through PRIME.
    enable = 1'b1; ack = 1'b1; count_in = 8'd21;
    tick(); chk_all("ack_alarm", 1, 0, 0, 0, 0);
    ack = 1'b0; count_in = 8'd22;
    tick(); chk_all("reprime", 2, 0, 0, 0, 0);
    count_in = 8'd5;
    tick(); chk_all("resume_wrap", 2, 0, 1, 1, 0);

    // Held value at threshold fires once; downward step is one wrap; stall is not.
    count_in = 8'd9;
    tick(); chk_all("pre_hold", 2, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      count_in = 8'd10;
      tick(); chk_all("hold10", 2, (i == 0) ? 1 : 0, 0, 1, 0);
    end
    count_in = 8'd200;
    tick(); chk_all("step200", 2, 0, 0, 1, 0);
    count_in = 8'd50;
    tick(); chk_all("step50", 2, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("hold50", 2, 0, 0, 2, 0);
    end
    threshold = 8'd50;
    tick(); chk_all("thr_change", 2, 0, 0, 2, 0);
    threshold = 8'd10;

    // Wrap and ack together at count 2: pulse still emitted, count cleared.
    ack = 1'b1; count_in = 8'd40;
    tick(); chk_all("wrap_ack", 2, 0, 1, 0, 0);
    ack = 1'b0; count_in = 8'd30;
    tick(); chk_all("w1", 2, 0, 1, 1, 0);
    count_in = 8'd20;
    tick(); chk_all("w2", 2, 0, 1, 2, 0);
    count_in = 8'd10;
    tick(); chk_all("w3_match", 2, 1, 1, 3, 0);

    // Asynchronous reset mid-TRACK, seen before the next edge.
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0; enable = 1'b1; count_in = 8'd100;
    tick(); chk_all("post_reset_prime", 1, 0, 0, 0, 0);
    count_in = 8'd5;
    tick(); chk_all("post_reset_track", 2, 0, 0, 0, 0);
    count_in = 8'd4;
    tick(); chk_all("post_reset_wrap", 2, 0, 1, 1, 0);

    // enable drop: cycle not evaluated even on a downward step; ack in IDLE clears.
    enable = 1'b0; count_in = 8'd0;
    tick(); chk_all("disable", 0, 0, 0, 1, 0);
    ack = 1'b1;
    tick(); chk_all("idle_ack", 0, 0, 0, 0, 0);
    ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
